// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the single-port SRAM sequencer.
//   ADDR_W_DEF / DATA_W_DEF : default macro geometry (4096 x 15)
//   state_e                 : sequencer state (CLEAR sweeps the macro, IDLE serves clients)
//   grant_e                 : which requester won the most recent accepted grant
//   REQ_WR / REQ_RD         : bit positions in the 2-bit request/grant vectors
package sram_ctrl_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 15;

  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;
  typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_e;
endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter for the write/read requesters.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : arbitration allowed this cycle (no grants when low)
//   req_i[1:0]    : request vector, bit REQ_WR = write, bit REQ_RD = read
//   gnt_o[1:0]    : one-hot (or zero) grant, combinational from req_i/en_i/history
//   accept_o      : a grant was issued (grant implies acceptance of that request)
module sram_rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       accept_o
);

  grant_e last_q, last_d;

  // Contention goes to whoever did not win last time; a lone request wins outright.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) gnt_o = (last_q == GNT_RD) ? 2'b01 : 2'b10;
      else        gnt_o = req_i;
    end
  end

  assign accept_o = |gnt_o;

  // History only moves when something is actually granted.
  always_comb begin
    last_d = last_q;
    if (gnt_o[REQ_WR])      last_d = GNT_WR;
    else if (gnt_o[REQ_RD]) last_d = GNT_RD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= GNT_RD;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Sequencer for one 1RW SRAM macro (registered read) shared by a write and a read client.
// After reset or clear_req it writes INIT_VAL to every entry, then arbitrates round-robin.
//   clock_i, reset_n_i          : clock, async active-low reset
//   clear_req_i                 : pulse, restart the full clear sweep
//   init_done_o                 : clear finished, requests may be accepted
//   wr_valid_i/wr_ready_o/...   : write request channel (addr, data)
//   rd_valid_i/rd_ready_o/...   : read request channel (addr)
//   rd_resp_valid_o/_data_o     : read response, exactly one cycle after acceptance
//   sram_*                      : direct drive of macro RW0_* pins
module sram_1rw_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              clear_req_i,
  output logic              init_done_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_resp_valid_o,
  output logic [DATA_W-1:0] rd_resp_data_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_en_o,
  output logic              sram_wmode_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        gnt;
  logic              accept;
  logic              arb_en;

  // clear_req wins over same-cycle requests: both readies stay low.
  assign arb_en = (state_q == IDLE) && !clear_req_i;

  sram_rr_arb2 u_arb (
    .clk_i    (clock_i),
    .rst_ni   (reset_n_i),
    .en_i     (arb_en),
    .req_i    ({rd_valid_i, wr_valid_i}),
    .gnt_o    (gnt),
    .accept_o (accept)
  );

  assign wr_ready_o  = gnt[REQ_WR];
  assign rd_ready_o  = gnt[REQ_RD];
  assign init_done_o = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    sram_en_o    = 1'b0;
    sram_wmode_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    unique case (state_q)
      CLEAR: begin
        sram_en_o    = 1'b1;
        sram_wmode_o = 1'b1;
        sram_addr_o  = clr_ptr_q;
        sram_wdata_o = INIT_VAL;
        // The pointer parks on all-ones when done; entry to CLEAR always reloads it.
        if (clear_req_i)            clr_ptr_d = '0;
        else if (clr_ptr_q == '1)   state_d   = IDLE;
        else                        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      end
      IDLE: begin
        if (clear_req_i) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else if (gnt[REQ_WR]) begin
          sram_en_o    = 1'b1;
          sram_wmode_o = 1'b1;
          sram_addr_o  = wr_addr_i;
          sram_wdata_o = wr_data_i;
        end else if (gnt[REQ_RD]) begin
          sram_en_o   = 1'b1;
          sram_addr_o = rd_addr_i;
        end
      end
      default: ;
    endcase
  end

  // Macro read data is registered inside the macro, so the response is the
  // accepted-read flag delayed by one cycle with rdata passed straight through.
  assign rd_pend_d       = accept & gnt[REQ_RD];
  assign rd_resp_valid_o = rd_pend_q;
  assign rd_resp_data_o  = sram_rdata_i;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule
